itcm_fetch_ctrl: RTL

//  Instruction-memory responder for the fetch stage: takes the fetch pc and returns instr_read_data

---
 rtl/itcm_fetch_ctrl_pkg.sv | 17 +
 rtl/itcm_fetch_ctrl_line_buf.sv | 76 +++++++
 rtl/itcm_fetch_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/itcm_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch-side instruction memory controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package itcm_fetch_ctrl_pkg;

   // RISC-V "addi x0, x0, 0", used to replace instructions whose bus response errored.
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
   localparam logic [31:0] ITCM_BASE_DEFAULT = 32'h0000_0000;
   localparam int          ITCM_AW_DEFAULT   = 14;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_REQ  = 2'd1,
      BUS_WAIT = 2'd2
   } bus_state_e;

endpackage

// File: rtl/itcm_fetch_ctrl_line_buf.sv
// imem_line_buf: 2-entry tag/data instruction buffer with combinational hit, probe and LRU fill.
// Latency: lookup is combinational; a fill is visible from the cycle after fill_vld.
// Backpressure: none; the fill port is always accepted and goes to the LRU / non-hit entry.
// Ports: lookup_tag -> hit/hit_data, probe_tag -> probe_hit (is this word buffered?),
//        fill_vld/fill_tag/fill_data write one entry per cycle.
module imem_line_buf
   import itcm_fetch_ctrl_pkg::*;
#(
   parameter int TAG_W  = 30,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TAG_W-1:0]  lookup_tag,
   input  logic [TAG_W-1:0]  probe_tag,
   input  logic              fill_vld,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [DATA_W-1:0] fill_data,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   output logic              probe_hit
);

   logic [1:0]        vld_q, vld_d;
   logic [TAG_W-1:0]  tag_q  [2];
   logic [TAG_W-1:0]  tag_d  [2];
   logic [DATA_W-1:0] data_q [2];
   logic [DATA_W-1:0] data_d [2];
   logic              lru_q, lru_d;
   logic [1:0]        match;
   logic              hit_idx;
   logic              victim;

   always_comb begin
      match[0]  = vld_q[0] && (tag_q[0] == lookup_tag);
      match[1]  = vld_q[1] && (tag_q[1] == lookup_tag);
      hit       = |match;
      hit_idx   = match[1];
      hit_data  = '0;
      if (hit) hit_data = data_q[hit_idx];
      probe_hit = (vld_q[0] && (tag_q[0] == probe_tag)) ||
                  (vld_q[1] && (tag_q[1] == probe_tag));

      // Never overwrite the entry currently feeding fetch.
      victim = hit ? ~hit_idx : lru_q;

      vld_d  = vld_q;
      tag_d  = tag_q;
      data_d = data_q;
      lru_d  = lru_q;
      if (fill_vld) begin
         vld_d[victim]  = 1'b1;
         tag_d[victim]  = fill_tag;
         data_d[victim] = fill_data;
         lru_d          = ~victim;
      end
      if (hit) lru_d = ~hit_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         lru_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         lru_q  <= lru_d;
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/itcm_fetch_ctrl.sv
// Fetch instruction responder: serves pc from the ITCM (with pc+4 prefetch) or the external bus.
// Latency: buffered hit 0 cycles, ITCM miss 1 cycle, bus miss = grant + response + 1 cycle.
// Backpressure: fetch holds pc while valid is low; ibus_req is held until ibus_gnt.
// Ports: pc -> instr_read_data(_valid); itcm_cs/itcm_addr/itcm_rdata single-cycle SRAM;
//        ibus_req/addr/gnt/rvalid/rdata/err external bus; ibus_fault error pulse for current pc.
module itcm_fetch_ctrl
   import itcm_fetch_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ITCM_BASE   = ITCM_BASE_DEFAULT,
   parameter int                    ITCM_AW     = ITCM_AW_DEFAULT,
   parameter bit                    PREFETCH_EN = 1'b1
) (
   input  logic                   cpu_clk,
   input  logic                   cpu_rst,
   input  logic [ADDR_WIDTH-1:0]  pc,
   output logic                   instr_read_data_valid,
   output logic [INSTR_WIDTH-1:0] instr_read_data,
   output logic                   itcm_cs,
   output logic [ITCM_AW-1:0]     itcm_addr,
   input  logic [INSTR_WIDTH-1:0] itcm_rdata,
   output logic                   ibus_req,
   output logic [ADDR_WIDTH-1:0]  ibus_addr,
   input  logic                   ibus_gnt,
   input  logic                   ibus_rvalid,
   input  logic [INSTR_WIDTH-1:0] ibus_rdata,
   input  logic                   ibus_err,
   output logic                   ibus_fault
);

   localparam int TAG_W   = ADDR_WIDTH - 2;
   localparam int RGN_LSB = ITCM_AW + 2;

   logic [TAG_W-1:0]       pc_tag, nxt_tag, issue_tag;
   logic                   pc_aligned, pc_in_itcm, nxt_in_itcm;
   logic                   buf_hit, buf_probe_hit, pend_hit, pend_probe, hit_any, bus_miss;
   logic [INSTR_WIDTH-1:0] buf_data;
   logic                   fill_vld, bus_fill;
   logic [TAG_W-1:0]       fill_tag;
   logic [INSTR_WIDTH-1:0] fill_data;

   // Outstanding ITCM read: tag of the word whose data shows up on itcm_rdata this cycle.
   logic                   pend_vld_q, pend_vld_d;
   logic [TAG_W-1:0]       pend_tag_q, pend_tag_d;

   bus_state_e             state_q;
   logic                   ibus_req_q, ibus_fault_q;
   logic [ADDR_WIDTH-1:0]  ibus_addr_q;

   assign pc_tag      = pc[ADDR_WIDTH-1:2];
   assign nxt_tag     = pc_tag + TAG_W'(1);
   assign pc_aligned  = (pc[1:0] == 2'b00);
   assign pc_in_itcm  = (pc[ADDR_WIDTH-1:RGN_LSB] == ITCM_BASE[ADDR_WIDTH-1:RGN_LSB]);
   assign nxt_in_itcm = (nxt_tag[TAG_W-1:ITCM_AW] == ITCM_BASE[ADDR_WIDTH-1:RGN_LSB]);

   // The in-flight ITCM word is forwarded straight from the SRAM so an ITCM miss costs 1 cycle.
   assign pend_hit   = pend_vld_q && (pend_tag_q == pc_tag);
   assign pend_probe = pend_vld_q && (pend_tag_q == nxt_tag);
   assign hit_any    = pc_aligned && (buf_hit || pend_hit);
   assign bus_miss   = pc_aligned && !pc_in_itcm && !hit_any;
   assign bus_fill   = (state_q == BUS_WAIT) && ibus_rvalid;

   always_comb begin
      instr_read_data_valid = hit_any;
      instr_read_data       = '0;
      if (hit_any) instr_read_data = buf_hit ? buf_data : itcm_rdata;

      itcm_cs   = 1'b0;
      issue_tag = '0;
      if (!cpu_rst && pc_aligned && pc_in_itcm) begin
         if (!hit_any) begin
            itcm_cs   = 1'b1;
            issue_tag = pc_tag;
         end else if (PREFETCH_EN && nxt_in_itcm && !buf_probe_hit && !pend_probe) begin
            itcm_cs   = 1'b1;
            issue_tag = nxt_tag;
         end
      end
      itcm_addr  = issue_tag[ITCM_AW-1:0];
      pend_vld_d = itcm_cs;
      pend_tag_d = issue_tag;

      // A bus response takes the single fill port; a colliding ITCM word is dropped and
      // simply re-read later if fetch still wants it.
      fill_vld  = bus_fill || pend_vld_q;
      fill_tag  = pend_tag_q;
      fill_data = itcm_rdata;
      if (bus_fill) begin
         fill_tag  = ibus_addr_q[ADDR_WIDTH-1:2];
         fill_data = ibus_err ? INSTR_WIDTH'(NOP_INSTR) : ibus_rdata;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         pend_vld_q <= 1'b0;
         pend_tag_q <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_tag_q <= pend_tag_d;
      end
   end

   // Bus FSM. A redirect never aborts an access; the response still fills under its own tag.
   // The fault pulse is registered so it coincides with the NOP becoming valid.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q      <= BUS_IDLE;
         ibus_req_q   <= 1'b0;
         ibus_addr_q  <= '0;
         ibus_fault_q <= 1'b0;
      end else begin
         ibus_fault_q <= 1'b0;
         case (state_q)
            BUS_IDLE: if (bus_miss) begin
               state_q     <= BUS_REQ;
               ibus_req_q  <= 1'b1;
               ibus_addr_q <= pc;
            end
            BUS_REQ: if (ibus_gnt) begin
               state_q    <= BUS_WAIT;
               ibus_req_q <= 1'b0;
            end
            BUS_WAIT: if (ibus_rvalid) begin
               state_q      <= BUS_IDLE;
               ibus_fault_q <= ibus_err && (pc == ibus_addr_q);
            end
            default: state_q <= BUS_IDLE;
         endcase
      end
   end

   assign ibus_req   = ibus_req_q;
   assign ibus_addr  = ibus_addr_q;
   assign ibus_fault = ibus_fault_q;

   imem_line_buf #(
      .TAG_W  (TAG_W),
      .DATA_W (INSTR_WIDTH)
   ) u_line_buf (
      .clk        (cpu_clk),
      .rst        (cpu_rst),
      .lookup_tag (pc_tag),
      .probe_tag  (nxt_tag),
      .fill_vld   (fill_vld),
      .fill_tag   (fill_tag),
      .fill_data  (fill_data),
      .hit        (buf_hit),
      .hit_data   (buf_data),
      .probe_hit  (buf_probe_hit)
   );

endmodule
